// File: rtl/hblur_box_rgb_if.sv
// rtl/hblur_box_rgb_if.sv - pixel in/out bundle for the horizontal box blur
interface hblur_box_rgb_if #(
    parameter int PIX_W = 8
);
    logic             in_valid;
    logic             in_sop;
    logic             in_sol;
    logic             blur_en;
    logic [PIX_W-1:0] in_r;
    logic [PIX_W-1:0] in_g;
    logic [PIX_W-1:0] in_b;
    logic             out_valid;
    logic             out_sop;
    logic [PIX_W-1:0] out_r;
    logic [PIX_W-1:0] out_g;
    logic [PIX_W-1:0] out_b;

    modport master (
        output in_valid, in_sop, in_sol, blur_en, in_r, in_g, in_b,
        input  out_valid, out_sop, out_r, out_g, out_b
    );

    modport slave (
        input  in_valid, in_sop, in_sol, blur_en, in_r, in_g, in_b,
        output out_valid, out_sop, out_r, out_g, out_b
    );
endinterface

// File: rtl/hblur_box_rgb.sv
// rtl/hblur_box_rgb.sv - 2^TAPS_LOG2-tap horizontal RGB box blur, two-cycle latency, bypass
// Define HBLUR_ROUND_EN for round-half-up averaging instead of truncation.
module hblur_box_rgb #(
    parameter int PIX_W     = 8,
    parameter int TAPS_LOG2 = 2
) (
    input logic             clk,
    input logic             reset_n,
    hblur_box_rgb_if.slave  bus
);
    localparam int N = 1 << TAPS_LOG2;
`ifdef HBLUR_ROUND_EN
    localparam int SUM_W = PIX_W + TAPS_LOG2 + 1;
`else
    localparam int SUM_W = PIX_W + TAPS_LOG2;
`endif

    logic [PIX_W-1:0] win     [3][N];
    logic [PIX_W-1:0] pix_in  [3];
    logic [PIX_W-1:0] s1_pix  [3];
    logic [PIX_W-1:0] out_pix [3];
    logic [SUM_W-1:0] sum     [3];
    logic [PIX_W-1:0] avg     [3];
    logic             s1_valid;
    logic             s1_sop;
    logic             s1_blur;
    logic             first_beat;
    logic             out_valid_q;
    logic             out_sop_q;
    logic             line_start;

    assign pix_in[0]  = bus.in_r;
    assign pix_in[1]  = bus.in_g;
    assign pix_in[2]  = bus.in_b;
    // first_beat makes the first pixel after reset a line start regardless of in_sol
    assign line_start = bus.in_sol | bus.in_sop | first_beat;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid   <= 1'b0;
            s1_sop     <= 1'b0;
            s1_blur    <= 1'b0;
            first_beat <= 1'b1;
            for (int c = 0; c < 3; c++) begin
                s1_pix[c] <= '0;
                for (int i = 0; i < N; i++) win[c][i] <= '0;
            end
        end else begin
            s1_valid <= bus.in_valid;
            s1_sop   <= bus.in_valid & bus.in_sop;
            if (bus.in_valid) begin
                first_beat <= 1'b0;
                s1_blur    <= bus.blur_en;
                for (int c = 0; c < 3; c++) begin
                    s1_pix[c] <= pix_in[c];
                    win[c][0] <= pix_in[c];
                    for (int i = 1; i < N; i++)
                        win[c][i] <= line_start ? pix_in[c] : win[c][i-1];
                end
            end
        end
    end

    // window already holds the stage-1 beat, so the sum lines up with s1_* controls
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            sum[c] = '0;
            for (int i = 0; i < N; i++) sum[c] = sum[c] + SUM_W'(win[c][i]);
`ifdef HBLUR_ROUND_EN
            avg[c] = PIX_W'((sum[c] + SUM_W'(N / 2)) >> TAPS_LOG2);
`else
            avg[c] = PIX_W'(sum[c] >> TAPS_LOG2);
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            for (int c = 0; c < 3; c++) out_pix[c] <= '0;
        end else begin
            out_valid_q <= s1_valid;
            out_sop_q   <= s1_valid & s1_sop;
            if (s1_valid) begin
                for (int c = 0; c < 3; c++) out_pix[c] <= s1_blur ? avg[c] : s1_pix[c];
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_sop   = out_sop_q;
    assign bus.out_r     = out_pix[0];
    assign bus.out_g     = out_pix[1];
    assign bus.out_b     = out_pix[2];
endmodule

// File: tb/tb_hblur_box_rgb.sv
// tb/tb_hblur_box_rgb.sv - table-driven scoreboard bench for hblur_box_rgb (N=4)
module tb_hblur_box_rgb;
    logic clk;
    logic reset_n;
    int   cyc;
    int   n_tests;
    int   n_fail;

    hblur_box_rgb_if #(.PIX_W(8)) bus ();

    hblur_box_rgb #(.PIX_W(8), .TAPS_LOG2(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int idle;
        bit sol;
        bit sop;
        bit blur;
        int r, g, b;
        int er, eg, eb;
    } vec_t;

    typedef struct {
        int r, g, b;
        bit sop;
        int cyc;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];
    exp_t e;

`ifdef HBLUR_ROUND_EN
    localparam int RND_LAST = 1;
`else
    localparam int RND_LAST = 0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic add(input int idle, input bit sol, input bit sop, input bit blur,
                       input int r, input int g, input int b,
                       input int er, input int eg, input int eb);
        vec_t v;
        v.idle = idle; v.sol = sol; v.sop = sop; v.blur = blur;
        v.r = r; v.g = g; v.b = b; v.er = er; v.eg = eg; v.eb = eb;
        vt.push_back(v);
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sol   = 1'($urandom_range(0, 1));
        bus.in_sop   = 1'($urandom_range(0, 1));
        bus.blur_en  = 1'($urandom_range(0, 1));
        bus.in_r     = 8'($urandom);
        bus.in_g     = 8'($urandom);
        bus.in_b     = 8'($urandom);
    endtask

    task automatic beat(input bit sol, input bit sop, input bit blur,
                        input int r, input int g, input int b,
                        input int er, input int eg, input int eb);
        exp_t x;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_sol   = sol;
        bus.in_sop   = sop;
        bus.blur_en  = blur;
        bus.in_r     = 8'(r);
        bus.in_g     = 8'(g);
        bus.in_b     = 8'(b);
        x.r = er; x.g = eg; x.b = eb; x.sop = sop; x.cyc = cyc;
        sb.push_back(x);
    endtask

    // scoreboard: each output beat must match the oldest expectation, exactly two cycles later
    always @(negedge clk) begin
        if (reset_n) begin
            if (sb.size() > 0 && cyc > sb[0].cyc + 2) begin
                check("missing_output", cyc, sb[0].cyc + 2);
                void'(sb.pop_front());
            end
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("out_r", int'(bus.out_r), e.r);
                    check("out_g", int'(bus.out_g), e.g);
                    check("out_b", int'(bus.out_b), e.b);
                    check("out_sop", int'(bus.out_sop), int'(e.sop));
                    check("latency", cyc, e.cyc + 2);
                end
            end else if (bus.out_sop) begin
                check("sop_without_valid", 1, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        reset_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_sol = 1'b0; bus.in_sop = 1'b0; bus.blur_en = 1'b0;
        bus.in_r = '0; bus.in_g = '0; bus.in_b = '0;

        // constant line
        for (int i = 0; i < 16; i++) add(0, i == 0, 0, 1, 100, 100, 100, 100, 100, 100);
        // step response
        add(0, 1, 0, 1,   0, 40, 255,   0, 40, 255);
        add(0, 0, 0, 1,   0, 40, 255,   0, 40, 255);
        add(0, 0, 0, 1,   0, 40, 255,   0, 40, 255);
        add(0, 0, 0, 1,   0, 40, 255,   0, 40, 255);
        add(0, 0, 0, 1, 200, 40,  55,  50, 40, 205);
        add(0, 0, 0, 1, 200, 40,  55, 100, 40, 155);
        add(0, 0, 0, 1, 200, 40,  55, 150, 40, 105);
        add(0, 0, 0, 1, 200, 40,  55, 200, 40,  55);
        // edge replication
        for (int i = 0; i < 4; i++) add(0, i == 0, 0, 1, 255, 255, 255, 255, 255, 255);
        add(0, 1, 0, 1, 80, 80, 80, 80, 80, 80);
        add(0, 0, 0, 1, 80, 80, 80, 80, 80, 80);
        // rounding
        add(0, 1, 0, 1, 0, 255, 255, 0, 255, 255);
        add(0, 0, 0, 1, 0, 255, 255, 0, 255, 255);
        add(0, 0, 0, 1, 1, 255, 255, 0, 255, 255);
        add(0, 0, 0, 1, 1, 255, 255, RND_LAST, 255, 255);
        // gaps, bypass, re-enable
        add(0, 1, 0, 1,   0,   0,   0,   0,   0,   0);
        add(0, 0, 0, 1,   0,   0,   0,   0,   0,   0);
        add(0, 0, 0, 1,   0,   0,   0,   0,   0,   0);
        add(0, 0, 0, 1,   0,   0,   0,   0,   0,   0);
        add(3, 0, 0, 1, 200, 200, 200,  50,  50,  50);
        add(0, 0, 0, 0, 200, 200, 200, 200, 200, 200);
        add(0, 0, 0, 1, 200, 200, 200, 150, 150, 150);
        add(0, 0, 0, 1, 200, 200, 200, 200, 200, 200);
        // sop alone implies line start
        add(0, 0, 1, 1, 40, 40, 40, 40, 40, 40);
        add(0, 0, 0, 1, 80, 80, 80, 50, 50, 50);
        add(0, 1, 1, 1, 12, 12, 12, 12, 12, 12);

        #12;
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_sop",   int'(bus.out_sop),   0);
        check("rst_out_r",     int'(bus.out_r),     0);
        check("rst_out_g",     int'(bus.out_g),     0);
        check("rst_out_b",     int'(bus.out_b),     0);
        @(posedge clk);
        #2 reset_n = 1'b1;

        foreach (vt[k]) begin
            for (int j = 0; j < vt[k].idle; j++) idle_cycle();
            beat(vt[k].sol, vt[k].sop, vt[k].blur, vt[k].r, vt[k].g, vt[k].b,
                 vt[k].er, vt[k].eg, vt[k].eb);
        end
        for (int j = 0; j < 4; j++) idle_cycle();
        check("table_drained", sb.size(), 0);

        // reset while output valid, then first beat without sol
        beat(1, 0, 1, 90, 90, 90, 90, 90, 90);
        beat(0, 0, 1, 90, 90, 90, 90, 90, 90);
        beat(0, 0, 1, 90, 90, 90, 90, 90, 90);
        idle_cycle();
        for (int k = 0; k < 10 && !bus.out_valid; k++) @(negedge clk);
        check("pre_reset_valid", int'(bus.out_valid), 1);
        #1 reset_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(bus.out_valid), 0);
        check("midrst_out_r",     int'(bus.out_r),     0);
        check("midrst_out_g",     int'(bus.out_g),     0);
        check("midrst_out_b",     int'(bus.out_b),     0);
        sb.delete();
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        beat(0, 0, 1, 60, 60, 60, 60, 60, 60);
        beat(0, 0, 1, 60, 60, 60, 60, 60, 60);
        for (int j = 0; j < 5; j++) idle_cycle();
        check("final_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/hblur_box_rgb.md
Name: hblur_box_rgb

Overview:
- Parametrised horizontal box-blur filter for the RGB video stream in the camera processing path, between pixel unpacking and the colour-detection stages.
- Averages each pixel with the preceding 2^TAPS_LOG2 - 1 pixels of the same line, with edge replication at line start.
- Provides valid-qualified input and output, a runtime bypass, and fixed two-cycle latency.

Parameters:
- PIX_W, 8, bits per colour channel.
- TAPS_LOG2, 2, log2 of the window length N. Legal range is 1..4, so N is 2..16.

Ports:
- clk, input, 1, system clock; all logic is on the rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, the input pixel is valid this cycle.
- in_sop, input, 1, start of packet/frame; qualified by in_valid.
- in_sol, input, 1, first pixel of a line; qualified by in_valid.
- blur_en, input, 1, 1 = blurred output, 0 = pass-through; sampled per valid beat.
- in_r, in_g, in_b, input, PIX_W each, input channels.
- out_valid, output, 1, the output pixel is valid.
- out_sop, output, 1, delayed in_sop aligned to output.
- out_r, out_g, out_b, output, PIX_W each, output channels.

Behaviour:
- Reset (reset_n low, asynchronous):
  - All window taps, pipeline registers and outputs clear to 0.
  - out_valid = 0, out_sop = 0.
  - Reset asserted mid-line discards all in-flight data. The first beat after release is treated as line start, even if in_sol = 0.
- Per channel, the window is an N-entry shift register W[0..N-1].
- Stage 1 (on in_valid = 1):
  - If in_sol = 1, in_sop = 1, or this is the first beat since reset, every entry W[0..N-1] is loaded with the incoming pixel (edge replication).
  - Otherwise W[i] <= W[i-1] for i = N-1..1, and W[0] <= the incoming pixel.
  - Stage-1 registers capture the incoming pixel (for bypass), blur_en, in_sop and valid.
- When in_valid = 0, the window holds unchanged and a stage-1 bubble (valid = 0) is produced. Gaps never corrupt the window.
- Stage 2:
  - sum = W[0] + ... + W[N-1], computed at full width PIX_W + TAPS_LOG2 with no overflow.
  - avg = sum >> TAPS_LOG2, truncated by default.
  - The out_* registers load avg when the stage-1 blur_en = 1, else the stage-1 bypass pixel.
  - out_valid and out_sop load the stage-1 valid and sop.
- Latency:
  - An input beat at cycle t appears at the outputs at cycle t+2, with out_valid = 1 for exactly one cycle per input beat.
  - Throughput is one pixel per clock.
- When out_valid = 0, the out_* data holds its last value and is don't-care to consumers. out_sop = 0 whenever out_valid = 0.
- blur_en toggling mid-line:
  - It affects only the beats sampled with the new value.
  - The window keeps updating in bypass mode, so re-enabling mid-line gives correct averages immediately.
- Simultaneous in_sol and in_sop: a single replication. in_sop alone also implies line start.
- Control inputs are ignored when in_valid = 0.
- There is no backpressure input; downstream must accept every out_valid beat.

Optional Feature:
- Macro: HBLUR_ROUND_EN.
- Defined: avg = (sum + 2^(TAPS_LOG2-1)) >> TAPS_LOG2, i.e. round half up. The sum width is PIX_W + TAPS_LOG2 + 1 internally; the result never exceeds 2^PIX_W - 1 and needs no clamp.
- Undefined: truncating shift, as specified above.

Test Plan:
- Constant line: N=4, sol beat plus 15 beats all R=G=B=100 -> every output 100, out_valid high 2 cycles after each input beat.
- Step response: N=4, R line 0(sol),0,0,0,200,200,200,200 -> out_r 0,0,0,0,50,100,150,200.
- Edge replication: previous line all 255; new line 80(sol),80 -> first output 80, with no 255 contribution.
- Rounding: N=4, R 0(sol),0,1,1 -> last output 0 without HBLUR_ROUND_EN, 1 with it. 255 everywhere -> 255 in both builds.
- Gaps and bypass: 0(sol),0,0,0,200 with 3 idle cycles before the 200 -> output 50, and out_valid low during the gap. The same beat with blur_en = 0 -> 200. 200 then re-enable -> next beat averages correctly.
- Reset mid-line: assert reset_n low while out_valid = 1 -> outputs 0 immediately. Then release and send beat 60 with in_sol = 0 -> output 60, replicated as line start.
